afd_ctrl_sequencer: RTL and testbench
=====================================

AFD_CTRL_SEQUENCER -- requirements
Module: afd_ctrl_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 8: width of the snapshot update counter.
REQ-002 SHALL have port clk, input, 1: the single clock for all logic.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1: level request to run the AFD extractor.
REQ-005 SHALL have port av_address, output, 4: Avalon-MM master address to the extractor slave.
REQ-006 SHALL have port av_read, output, 1: read strobe; readdata is valid exactly one cycle later.
REQ-007 SHALL have port av_readdata, input, 16: slave read data.
REQ-008 SHALL have port av_write, output, 1: write strobe.
REQ-009 SHALL have port av_writedata, output, 16: write data.
REQ-010 SHALL have port av_interrupt, input, 1: level interrupt from the slave.
REQ-011 SHALL have ports afd_code (4), ar (1), bar_flags (4), bar_value1 (16), bar_value2 (16) and afd_valid (1), all outputs, forming the committed snapshot.
REQ-012 SHALL have port snap_update, output, 1: one-cycle pulse on each snapshot commit.
REQ-013 SHALL have port update_count, output, CNT_W: number of commits, wrapping.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE and WAIT_IRQ.

Function
REQ-015 SHALL implement states IDLE, GO_WR, WAIT_IRQ, RD_ISSUE, RD_CAPT, CLR_WR, COMMIT and STOP_WR.
REQ-016 IDLE: enable=1 SHALL go to GO_WR; GO_WR SHALL drive one cycle of av_write=1, address 0, data 0x0001, then go to WAIT_IRQ.
REQ-017 WAIT_IRQ: enable=0 SHALL go to STOP_WR, which takes priority over the interrupt; otherwise av_interrupt=1 SHALL go to RD_ISSUE with the read index at 0.
REQ-018 The read index SHALL walk addresses 3, 4, 5, 6, 7, 8 in order, and each read SHALL take 2 cycles:
- RD_ISSUE: av_read=1, address = current index.
- RD_CAPT: latch av_readdata into shadow registers; advance the index, or go to CLR_WR after address 8.
REQ-019 Capture mapping SHALL be: addr 3 [3:0] to afd_code; 4 [0] to ar; 5 [3:0] to bar_flags; 6 to bar_value1; 7 to bar_value2; 8 [0] to afd_valid.
REQ-020 CLR_WR SHALL drive one cycle of av_write=1, address 2, data 0x0000, then go to COMMIT.
REQ-021 COMMIT SHALL copy all shadow registers to the outputs in the same cycle (atomic), pulse snap_update, and increment update_count modulo 2^CNT_W, wrapping from 0xFF to 0x00 at CNT_W=8.
REQ-022 After COMMIT:
- av_interrupt still 1 (a new event arrived during the sequence) and enable=1 SHALL go directly to RD_ISSUE.
- enable=0 SHALL go to STOP_WR.
- Otherwise SHALL go to WAIT_IRQ.
REQ-023 enable falling during RD_ISSUE..COMMIT SHALL NOT abort the sequence; the sequence completes and then goes to STOP_WR.
REQ-024 STOP_WR SHALL drive one cycle of av_write=1, address 0, data 0x0000, then go to IDLE; the snapshot outputs SHALL hold their values.
REQ-025 av_read and av_write SHALL never be high together, and SHALL be 0 in every state not listed above.
REQ-026 av_address and av_writedata SHALL be 0 whenever the corresponding strobe is low.
REQ-027 Latency from av_interrupt sampled high in WAIT_IRQ to the snap_update pulse SHALL be 15 cycles: 1 to RD_ISSUE, 12 of reads, 1 CLR_WR, 1 COMMIT.
REQ-028 Outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-029 rst=1 SHALL asynchronously force state IDLE, read index 0, and all outputs and shadow registers to 0.
REQ-030 Reset asserted mid-sequence SHALL discard the shadow data without committing it, and SHALL leave both strobes low starting in the reset cycle.

Structure
REQ-031 State encodings, register addresses (0 control, 2 interrupt, 3-8 data) and write values SHALL be in the shared package afd_pkg.
REQ-032 The design SHALL have one sub-module, afd_snapshot_regs, holding the shadow and committed register banks and the commit logic.

Verification
REQ-033 Reset, then enable=1: GO_WR write to addr 0 with data 0x0001 on cycle 1; busy=0 in WAIT_IRQ.
REQ-034 Slave returns 0x000A, 1, 0x0005, 0x1234, 0xABCD, 1 and interrupt is pulsed: snap_update 15 cycles later; afd_code=0xA, ar=1, bar_flags=5, bar_value1=0x1234, bar_value2=0xABCD, afd_valid=1; update_count=1.
REQ-035 Interrupt held high through CLR_WR: a second read sequence starts with no WAIT_IRQ cycle; update_count=2.
REQ-036 enable dropped at the address-5 read: sequence completes and commits, then STOP_WR writes addr 0 with data 0, then IDLE.
REQ-037 rst pulsed during the address-7 read: outputs read 0, no snap_update, and no strobes after reset.
REQ-038 256 interrupt events: update_count wraps to 0x00, and on every read and write cycle read/write exclusivity holds.

Source files
------------

// File: rtl/afd_pkg.sv
// Shared encodings, register map and write values for the AFD
// extractor control sequencer.
package afd_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GO_WR    = 3'd1,
        S_WAIT_IRQ = 3'd2,
        S_RD_ISSUE = 3'd3,
        S_RD_CAPT  = 3'd4,
        S_CLR_WR   = 3'd5,
        S_COMMIT   = 3'd6,
        S_STOP_WR  = 3'd7
    } state_t;

    localparam logic [3:0] ADDR_CTRL  = 4'd0;
    localparam logic [3:0] ADDR_IRQ   = 4'd2;
    localparam logic [3:0] ADDR_CODE  = 4'd3;
    localparam logic [3:0] ADDR_AR    = 4'd4;
    localparam logic [3:0] ADDR_FLAGS = 4'd5;
    localparam logic [3:0] ADDR_VAL1  = 4'd6;
    localparam logic [3:0] ADDR_VAL2  = 4'd7;
    localparam logic [3:0] ADDR_VALID = 4'd8;

    localparam logic [15:0] WR_GO      = 16'h0001;
    localparam logic [15:0] WR_IRQ_CLR = 16'h0000;
    localparam logic [15:0] WR_STOP    = 16'h0000;

    localparam logic [2:0] RD_LAST_IDX = 3'd5;

    typedef struct packed {
        logic [3:0]  code;
        logic        ar;
        logic [3:0]  flags;
        logic [15:0] value1;
        logic [15:0] value2;
        logic        valid;
    } snapshot_t;

    function automatic logic [3:0] rd_addr(input logic [2:0] idx);
        return ADDR_CODE + {1'b0, idx};
    endfunction

endpackage

// File: rtl/afd_snapshot_regs.sv
// Shadow and committed snapshot banks; a commit copies the whole
// shadow bank at once so consumers never see a half-updated snapshot.
module afd_snapshot_regs
    import afd_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [3:0]       capt_addr,
    input  logic [15:0]      rdata,
    input  logic             commit,
    output snapshot_t        snap,
    output logic             snap_update,
    output logic [CNT_W-1:0] update_count
);

    snapshot_t shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (capture) begin
            case (capt_addr)
                ADDR_CODE:  shadow.code   <= rdata[3:0];
                ADDR_AR:    shadow.ar     <= rdata[0];
                ADDR_FLAGS: shadow.flags  <= rdata[3:0];
                ADDR_VAL1:  shadow.value1 <= rdata;
                ADDR_VAL2:  shadow.value2 <= rdata;
                ADDR_VALID: shadow.valid  <= rdata[0];
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap         <= '0;
            snap_update  <= 1'b0;
            update_count <= '0;
        end else begin
            snap_update <= commit;
            if (commit) begin
                snap         <= shadow;
                update_count <= update_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/afd_ctrl_sequencer.sv
// Avalon-MM master that arms the AFD extractor, reads its result
// registers on each interrupt and publishes them as one snapshot.
module afd_ctrl_sequencer
    import afd_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [3:0]       av_address,
    output logic             av_read,
    input  logic [15:0]      av_readdata,
    output logic             av_write,
    output logic [15:0]      av_writedata,
    input  logic             av_interrupt,
    output logic [3:0]       afd_code,
    output logic             ar,
    output logic [3:0]       bar_flags,
    output logic [15:0]      bar_value1,
    output logic [15:0]      bar_value2,
    output logic             afd_valid,
    output logic             snap_update,
    output logic [CNT_W-1:0] update_count,
    output logic             busy
);

    state_t     state, state_nx;
    logic [2:0] rd_idx, rd_idx_nx;
    logic       rd_nx, wr_nx, busy_nx;
    logic [3:0] addr_nx;
    logic [15:0] wdata_nx;
    snapshot_t  snap;

    always_comb begin
        state_nx  = state;
        rd_idx_nx = rd_idx;
        unique case (state)
            S_IDLE: begin
                if (enable) state_nx = S_GO_WR;
            end
            S_GO_WR: state_nx = S_WAIT_IRQ;
            S_WAIT_IRQ, S_COMMIT: begin
                // a stop request wins over a pending interrupt
                if (!enable) begin
                    state_nx = S_STOP_WR;
                end else if (av_interrupt) begin
                    state_nx  = S_RD_ISSUE;
                    rd_idx_nx = '0;
                end else begin
                    state_nx = S_WAIT_IRQ;
                end
            end
            S_RD_ISSUE: state_nx = S_RD_CAPT;
            S_RD_CAPT: begin
                if (rd_idx == RD_LAST_IDX) begin
                    state_nx  = S_CLR_WR;
                    rd_idx_nx = '0;
                end else begin
                    state_nx  = S_RD_ISSUE;
                    rd_idx_nx = rd_idx + 3'd1;
                end
            end
            S_CLR_WR:  state_nx = S_COMMIT;
            S_STOP_WR: state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // bus outputs are decoded from the next state so the registered
    // strobes line up with the state that owns them
    always_comb begin
        rd_nx    = 1'b0;
        wr_nx    = 1'b0;
        addr_nx  = '0;
        wdata_nx = '0;
        busy_nx  = !(state_nx inside {S_IDLE, S_WAIT_IRQ});
        unique case (state_nx)
            S_GO_WR: begin
                wr_nx    = 1'b1;
                addr_nx  = ADDR_CTRL;
                wdata_nx = WR_GO;
            end
            S_RD_ISSUE: begin
                rd_nx   = 1'b1;
                addr_nx = rd_addr(rd_idx_nx);
            end
            S_CLR_WR: begin
                wr_nx    = 1'b1;
                addr_nx  = ADDR_IRQ;
                wdata_nx = WR_IRQ_CLR;
            end
            S_STOP_WR: begin
                wr_nx    = 1'b1;
                addr_nx  = ADDR_CTRL;
                wdata_nx = WR_STOP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            rd_idx       <= '0;
            av_read      <= 1'b0;
            av_write     <= 1'b0;
            av_address   <= '0;
            av_writedata <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nx;
            rd_idx       <= rd_idx_nx;
            av_read      <= rd_nx;
            av_write     <= wr_nx;
            av_address   <= addr_nx;
            av_writedata <= wdata_nx;
            busy         <= busy_nx;
        end
    end

    afd_snapshot_regs #(
        .CNT_W (CNT_W)
    ) u_regs (
        .clk          (clk),
        .rst          (rst),
        .capture      (state == S_RD_CAPT),
        .capt_addr    (rd_addr(rd_idx)),
        .rdata        (av_readdata),
        .commit       (state == S_COMMIT),
        .snap         (snap),
        .snap_update  (snap_update),
        .update_count (update_count)
    );

    assign afd_code   = snap.code;
    assign ar         = snap.ar;
    assign bar_flags  = snap.flags;
    assign bar_value1 = snap.value1;
    assign bar_value2 = snap.value2;
    assign afd_valid  = snap.valid;

endmodule

// File: tb/tb_afd_ctrl_sequencer.sv
// Randomized bench for afd_ctrl_sequencer against a script-queue
// model of the bus transactions, plus directed literal checks.
module tb_afd_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  av_address;
    logic        av_read;
    logic [15:0] av_readdata;
    logic        av_write;
    logic [15:0] av_writedata;
    logic        av_interrupt;
    logic [3:0]  afd_code;
    logic        ar;
    logic [3:0]  bar_flags;
    logic [15:0] bar_value1;
    logic [15:0] bar_value2;
    logic        afd_valid;
    logic        snap_update;
    logic [7:0]  update_count;
    logic        busy;

    afd_ctrl_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .av_address   (av_address),
        .av_read      (av_read),
        .av_readdata  (av_readdata),
        .av_write     (av_write),
        .av_writedata (av_writedata),
        .av_interrupt (av_interrupt),
        .afd_code     (afd_code),
        .ar           (ar),
        .bar_flags    (bar_flags),
        .bar_value1   (bar_value1),
        .bar_value2   (bar_value2),
        .afd_valid    (afd_valid),
        .snap_update  (snap_update),
        .update_count (update_count),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // one expected bus cycle; dec says what decides the following cycle
    localparam logic [1:0] D_NONE = 2'd0;
    localparam logic [1:0] D_IDLE = 2'd1;
    localparam logic [1:0] D_WAIT = 2'd2;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [3:0]  addr;
        logic [15:0] wd;
        logic        busy;
        logic [3:0]  cap;
        logic        com;
        logic [1:0]  dec;
    } rec_t;

    typedef struct packed {
        logic [3:0]  code;
        logic        ar;
        logic [3:0]  flags;
        logic [15:0] v1;
        logic [15:0] v2;
        logic        valid;
    } snap_t;

    function automatic rec_t mk(logic rd, logic wr, logic [3:0] a,
                                logic [15:0] wd, logic bz,
                                logic [3:0] cap, logic com,
                                logic [1:0] dec);
        rec_t r;
        r = '{rd, wr, a, wd, bz, cap, com, dec};
        return r;
    endfunction

    rec_t       cur;
    rec_t       q[$];
    snap_t      sh, m_out;
    logic       m_snap;
    logic [7:0] m_cnt;
    int         m_commits;

    task automatic model_reset();
        q.delete();
        cur    = mk(0, 0, 0, 0, 0, 0, 0, D_IDLE);
        sh     = '0;
        m_out  = '0;
        m_snap = 1'b0;
        m_cnt  = '0;
    endtask

    task automatic push_reads();
        for (int a = 3; a <= 8; a++) begin
            q.push_back(mk(1, 0, 4'(a), 0, 1, 0, 0, D_NONE));
            q.push_back(mk(0, 0, 0, 0, 1, 4'(a), 0, D_NONE));
        end
        q.push_back(mk(0, 1, 4'd2, 16'h0000, 1, 0, 0, D_NONE));
        q.push_back(mk(0, 0, 0, 0, 1, 0, 1, D_WAIT));
    endtask

    task automatic model_step(input logic en, input logic irq,
                              input logic [15:0] rd);
        m_snap = 1'b0;
        case (cur.cap)
            4'd3: sh.code  = rd[3:0];
            4'd4: sh.ar    = rd[0];
            4'd5: sh.flags = rd[3:0];
            4'd6: sh.v1    = rd;
            4'd7: sh.v2    = rd;
            4'd8: sh.valid = rd[0];
            default: ;
        endcase
        if (cur.com) begin
            m_out  = sh;
            m_snap = 1'b1;
            m_cnt  = m_cnt + 8'd1;
            m_commits++;
        end
        if (q.size() == 0) begin
            if (cur.dec == D_IDLE) begin
                if (en) begin
                    q.push_back(mk(0, 1, 0, 16'h0001, 1, 0, 0, D_NONE));
                    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, D_WAIT));
                end else begin
                    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, D_IDLE));
                end
            end else begin
                if (!en) begin
                    q.push_back(mk(0, 1, 0, 16'h0000, 1, 0, 0, D_NONE));
                    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, D_IDLE));
                end else if (irq) begin
                    push_reads();
                end else begin
                    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, D_WAIT));
                end
            end
        end
        cur = q.pop_front();
    endtask

    logic [15:0] tbl [16];
    bit          rand_data = 1'b0;
    bit          pend = 1'b0;
    logic [3:0]  pend_addr = '0;
    bit          chk_en = 1'b0;

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else model_step(enable, av_interrupt, av_readdata);
        #1;
        if (pend && !rand_data) av_readdata = tbl[pend_addr];
        else av_readdata = 16'($urandom);
        pend      = av_read;
        pend_addr = av_address;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("bus", 64'({av_read, av_write, av_address, av_writedata}),
                64'({cur.rd, cur.wr, cur.addr, cur.wd}));
            chk("busy", 64'(busy), 64'(cur.busy));
            chk("snapshot",
                64'({afd_code, ar, bar_flags, bar_value1, bar_value2,
                     afd_valid}),
                64'(m_out));
            chk("snap_update", 64'(snap_update), 64'(m_snap));
            chk("update_count", 64'(update_count), 64'(m_cnt));
            chk("rw_excl", 64'(av_read & av_write), 64'(0));
        end
    end

    task automatic wait_snap(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            n++;
            if (snap_update) return;
        end
        n = -1;
    endtask

    task automatic wait_read(input logic [3:0] a, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (av_read && av_address == a) begin
                ok = 1'b1;
                return;
            end
            cyc();
        end
    endtask

    int n;
    bit ok, saw_idle, saw_wrap;

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        av_interrupt = 1'b0;
        av_readdata  = '0;
        m_commits    = 0;
        for (int i = 0; i < 16; i++) tbl[i] = 16'h0;
        tbl[3] = 16'h000A; tbl[4] = 16'h0001; tbl[5] = 16'h0005;
        tbl[6] = 16'h1234; tbl[7] = 16'hABCD; tbl[8] = 16'h0001;
        model_reset();
        cyc();
        chk_en = 1'b1;
        cyc();
        chk("reset_state",
            64'({av_read, av_write, busy, snap_update, update_count,
                 afd_code, afd_valid}), 64'(0));
        rst    = 1'b0;
        enable = 1'b1;
        cyc();
        chk("go_wr", 64'({av_write, av_read, av_address, av_writedata}),
            64'({1'b1, 1'b0, 4'h0, 16'h0001}));
        cyc();
        chk("wait_busy", 64'(busy), 64'(0));

        // interrupt cycle, then 14 more edges until the pulse is seen
        av_interrupt = 1'b1;
        cyc();
        av_interrupt = 1'b0;
        wait_snap(n);
        chk("latency", 64'(n), 64'(14));
        chk("code", 64'(afd_code), 64'h0A);
        chk("ar", 64'(ar), 64'h1);
        chk("flags", 64'(bar_flags), 64'h5);
        chk("value1", 64'(bar_value1), 64'h1234);
        chk("value2", 64'(bar_value2), 64'hABCD);
        chk("valid", 64'(afd_valid), 64'h1);
        chk("count1", 64'(update_count), 64'h1);

        av_interrupt = 1'b1;
        wait_snap(n);
        saw_idle = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            n++;
            if (!busy) saw_idle = 1'b1;
            if (snap_update) break;
        end
        chk("b2b_gap", 64'(n), 64'(14));
        chk("b2b_no_wait", 64'(saw_idle), 64'(0));
        chk("count3", 64'(update_count), 64'h3);
        av_interrupt = 1'b0;
        wait_snap(n);
        chk("drain_snap", 64'(n > 0), 64'(1));

        av_interrupt = 1'b1;
        cyc();
        av_interrupt = 1'b0;
        wait_read(4'd5, ok);
        chk("reach_rd5", 64'(ok), 64'(1));
        enable = 1'b0;
        wait_snap(n);
        chk("stop_commit", 64'(update_count), 64'h5);
        chk("stop_wr", 64'({av_write, av_read, av_address, av_writedata}),
            64'({1'b1, 1'b0, 4'h0, 16'h0000}));
        cyc();
        chk("stop_idle", 64'({busy, av_write, av_read}), 64'(0));
        chk("stop_hold", 64'(afd_code), 64'h0A);

        enable = 1'b1;
        cyc();
        cyc();
        av_interrupt = 1'b1;
        cyc();
        av_interrupt = 1'b0;
        wait_read(4'd7, ok);
        chk("reach_rd7", 64'(ok), 64'(1));
        #2;
        rst    = 1'b1;
        enable = 1'b0;
        model_reset();
        #1;
        chk("rst_zero",
            64'({av_read, av_write, busy, snap_update, update_count,
                 afd_code, ar, bar_flags, afd_valid}), 64'(0));
        chk("rst_vals", 64'({bar_value1, bar_value2}), 64'(0));
        cyc();
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("post_rst_quiet",
                64'({av_read, av_write, snap_update}), 64'(0));
        end

        rand_data = 1'b1;
        saw_wrap  = 1'b0;
        m_commits = 0;
        for (int i = 0; i < 12000 && m_commits < 260; i++) begin
            enable       = ($urandom_range(0, 99) < 97);
            av_interrupt = 1'($urandom_range(0, 1));
            cyc();
            if (snap_update && update_count == 8'h00) saw_wrap = 1'b1;
        end
        chk("commit_budget", 64'(m_commits >= 256), 64'(1));
        chk("count_wrap", 64'(saw_wrap), 64'(1));

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
